ifetch: RTL and testbench

Instruction fetch stage for the 16-bit single-issue CPU, directly upstream of `maindec`. It holds the program counter and issues word reads to a synchronous instruction memory with 1-cycle latency. Returned words are buffered in a 2-entry queue and presented to decode with a valid/ready handshake. Branch and jump redirects from the datapath flush all queued and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_if.sv | 39 +++
 rtl/ifetch_fetch_fifo.sv | 77 +++++++
 rtl/ifetch.sv | 162 ++++++++++++++++
 tb/tb_ifetch.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the ifetch instruction-fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    // Opcode field of a 16-bit instruction word, as consumed by maindec.
    function automatic logic [OP_W-1:0] op_of(input logic [15:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side handshake signals.
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) ();

    logic            imem_en;
    logic [AW-1:0]   imem_addr;
    logic [DW-1:0]   imem_rdata;
    logic            redirect_valid;
    logic [AW-1:0]   redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   instr;
    logic [OP_W-1:0] op;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   pc_plus1;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output instr, op, pc, pc_plus1
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  instr, op, pc, pc_plus1
    );

endinterface

// File: rtl/ifetch_fetch_fifo.sv
// Two-entry shift queue; the head is always entry 0 so the outputs come straight from flops.
module fetch_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop_ok_s, push_ok_s;

    assign empty_o   = (cnt_q == 2'd0);
    assign full_o    = (cnt_q == 2'd2);
    assign count_o   = cnt_q;
    assign dout_o    = e0_q;
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Next-state of the queue; flush overrides any same-cycle push or pop.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din_i;
                    end else begin
                        e0_d = din_i;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d = din_i;
                    end else begin
                        e1_d = din_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, 1-cycle imem request tracking, 2-entry output queue.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IFETCH_PERF_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall,
`endif
    ifetch_if.master    bus
);

    localparam int QW = AW + DW;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic          inflight_q, inflight_d;
    logic          issue_s, credit_ok_s, pop_s, push_s;
    logic          full_s, empty_s;
    logic [1:0]    count_s;
    logic [QW-1:0] head_s;

    assign pop_s  = !empty_s && bus.out_ready;
    // A redirect kills the response landing this cycle.
    assign push_s = inflight_q && !bus.redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  begin
                if (bus.redirect_valid) begin
                    state_d = ST_BUBBLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_BUBBLE: begin
                if (bus.redirect_valid) begin
                    state_d = ST_BUBBLE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // Request issue: queued + outstanding - popped must stay below two.
    always_comb begin
        issue_s = 1'b0;
        if (inflight_q) begin
            credit_ok_s = (count_s == 2'd0) || ((count_s == 2'd1) && pop_s);
        end else begin
            credit_ok_s = !full_s || pop_s;
        end
        if (!reset && !bus.redirect_valid &&
            ((state_q == ST_FETCH) || (state_q == ST_RESET))) begin
            issue_s = credit_ok_s;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign bus.imem_en   = issue_s;
    assign bus.imem_addr = pc_q;

    // PC and in-flight request tracking.
    always_comb begin
        inflight_d = issue_s;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (issue_s) begin
            pc_d = pc_q + AW'(1);
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            iaddr_d = pc_q;
        end else begin
            iaddr_d = iaddr_q;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            iaddr_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            iaddr_q    <= iaddr_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .W (QW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (bus.redirect_valid),
        .din_i   ({iaddr_q, bus.imem_rdata}),
        .dout_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign bus.out_valid = !empty_s;
    assign bus.instr     = head_s[DW-1:0];
    assign bus.op        = op_of(head_s[15:0]);
    assign bus.pc        = head_s[QW-1:DW];
    assign bus.pc_plus1  = head_s[QW-1:DW] + AW'(1);

`ifdef IFETCH_PERF_EN
    logic [15:0] fetched_q, stall_q;

    // Free-running event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= 16'd0;
            stall_q   <= 16'd0;
        end else begin
            if (pop_s) begin
                fetched_q <= fetched_q + 16'd1;
            end else begin
                fetched_q <= fetched_q;
            end
            if (!empty_s && !bus.out_ready) begin
                stall_q <= stall_q + 16'd1;
            end else begin
                stall_q <= stall_q;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, streaming, stall, redirects, PC wrap, reset mid-run.
module tb_ifetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_viol = 0;

    ifetch_if #(.AW(16), .DW(16)) bus_a ();
    ifetch_if #(.AW(16), .DW(16)) bus_b ();

`ifdef IFETCH_PERF_EN
    logic [15:0] pf_a, ps_a, pf_b, ps_b;
`endif

    ifetch #(.AW(16), .DW(16), .RESET_PC(16'h0000)) dut_a (
        .clk          (clk),
        .reset        (reset_a),
`ifdef IFETCH_PERF_EN
        .perf_fetched (pf_a),
        .perf_stall   (ps_a),
`endif
        .bus          (bus_a)
    );

    ifetch #(.AW(16), .DW(16), .RESET_PC(16'hFFFE)) dut_b (
        .clk          (clk),
        .reset        (reset_b),
`ifdef IFETCH_PERF_EN
        .perf_fetched (pf_b),
        .perf_stall   (ps_b),
`endif
        .bus          (bus_b)
    );

    // Synchronous instruction memory: word[k] = 16'hA000 + k.
    always @(posedge clk) begin
        if (bus_a.imem_en) bus_a.imem_rdata <= 16'hA000 + bus_a.imem_addr;
        if (bus_b.imem_en) bus_b.imem_rdata <= 16'hA000 + bus_b.imem_addr;
    end

    // Queue full while a response lands must never happen.
    always @(negedge clk) begin
        if (!reset_a && dut_a.full_s && dut_a.inflight_q) n_viol++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset on DUT A; returns settled inside cycle 0.
    task automatic start_a(input logic rdy);
        reset_a = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.out_ready = rdy;
        next_cycle();
        next_cycle();
        reset_a = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        bus_a.out_ready = 1'b1;
        bus_a.redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.out_valid} !== 2'b00) begin
            n_err++; $display("FAIL reset_en_valid: got %b want 00", {bus_a.imem_en, bus_a.out_valid});
        end
        n_vec++;
        if (bus_a.imem_addr !== 16'h0000) begin
            n_err++; $display("FAIL reset_addr: got %h want 0000", bus_a.imem_addr);
        end
        n_vec++;
        if ({bus_a.instr, bus_a.op, bus_a.pc, bus_a.pc_plus1} !== {16'h0000, 3'b000, 16'h0000, 16'h0001}) begin
            n_err++; $display("FAIL reset_outputs: got %h/%b/%h/%h want 0000/000/0000/0001",
                              bus_a.instr, bus_a.op, bus_a.pc, bus_a.pc_plus1);
        end
`ifdef IFETCH_PERF_EN
        n_vec++;
        if ({pf_a, ps_a} !== 32'h0) begin
            n_err++; $display("FAIL reset_perf: got %h/%h want 0/0", pf_a, ps_a);
        end
`endif
    endtask

    task automatic test_stream();
        logic [15:0] exp_i;
        start_a(1'b1);
        n_vec++;
        if ({bus_a.imem_en, bus_a.imem_addr} !== {1'b1, 16'h0000}) begin
            n_err++; $display("FAIL stream_c0_req: got %b/%h want 1/0000", bus_a.imem_en, bus_a.imem_addr);
        end
        next_cycle(); #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.imem_en, bus_a.imem_addr} !== {1'b0, 1'b1, 16'h0001}) begin
            n_err++; $display("FAIL stream_c1: got %b/%b/%h want 0/1/0001",
                              bus_a.out_valid, bus_a.imem_en, bus_a.imem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #1;
            exp_i = 16'hA000 + 16'(k);
            n_vec++;
            if ({bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.op, bus_a.pc_plus1} !==
                {1'b1, 16'(k), exp_i, 3'b101, 16'(k + 1)}) begin
                n_err++; $display("FAIL stream_k%0d: got v=%b pc=%h i=%h op=%b p1=%h want v=1 pc=%h i=%h op=101 p1=%h",
                                  k, bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.op, bus_a.pc_plus1,
                                  16'(k), exp_i, 16'(k + 1));
            end
        end
`ifdef IFETCH_PERF_EN
        n_vec++;
        if (pf_a !== 16'd4) begin
            n_err++; $display("FAIL stream_perf_fetched: got %0d want 4", pf_a);
        end
`endif
    endtask

    task automatic test_stall();
        start_a(1'b1);
        next_cycle();
        next_cycle();
        bus_a.out_ready = 1'b0;
        #1;
        for (int c = 2; c <= 6; c++) begin
            if (c > 2) begin
                next_cycle(); #1;
            end
            n_vec++;
            if ({bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.imem_en} !== {1'b1, 16'h0000, 16'hA000, 1'b0}) begin
                n_err++; $display("FAIL stall_hold_c%0d: got v=%b pc=%h i=%h en=%b want v=1 pc=0000 i=a000 en=0",
                                  c, bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.imem_en);
            end
        end
        next_cycle();
        bus_a.out_ready = 1'b1;
        #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.imem_addr} !== {1'b1, 16'h0002}) begin
            n_err++; $display("FAIL stall_release_req: got %b/%h want 1/0002", bus_a.imem_en, bus_a.imem_addr);
        end
`ifdef IFETCH_PERF_EN
        n_vec++;
        if (ps_a !== 16'd5) begin
            n_err++; $display("FAIL stall_perf: got %0d want 5", ps_a);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                next_cycle(); #1;
            end
            n_vec++;
            if ({bus_a.out_valid, bus_a.pc, bus_a.instr} !== {1'b1, 16'(k), 16'hA000 + 16'(k)}) begin
                n_err++; $display("FAIL stall_drain_k%0d: got v=%b pc=%h i=%h want v=1 pc=%h",
                                  k, bus_a.out_valid, bus_a.pc, bus_a.instr, 16'(k));
            end
        end
    endtask

    task automatic test_redirect();
        start_a(1'b1);
        for (int c = 1; c <= 5; c++) next_cycle();
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 16'h0040;
        #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.out_valid, bus_a.pc} !== {1'b0, 1'b1, 16'h0003}) begin
            n_err++; $display("FAIL redir_c5: got en=%b v=%b pc=%h want en=0 v=1 pc=0003",
                              bus_a.imem_en, bus_a.out_valid, bus_a.pc);
        end
        next_cycle();
        bus_a.redirect_valid = 1'b0;
        #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.out_valid} !== 2'b00) begin
            n_err++; $display("FAIL redir_c6_bubble: got en=%b v=%b want 0/0", bus_a.imem_en, bus_a.out_valid);
        end
        next_cycle(); #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.imem_addr, bus_a.out_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            n_err++; $display("FAIL redir_c7_req: got en=%b a=%h v=%b want 1/0040/0",
                              bus_a.imem_en, bus_a.imem_addr, bus_a.out_valid);
        end
        next_cycle(); #1;
        n_vec++;
        if (bus_a.out_valid !== 1'b0) begin
            n_err++; $display("FAIL redir_c8_empty: got v=%b want 0", bus_a.out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            n_vec++;
            if ({bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.pc_plus1} !==
                {1'b1, 16'h0040 + 16'(k), 16'hA040 + 16'(k), 16'h0041 + 16'(k)}) begin
                n_err++; $display("FAIL redir_target_k%0d: got v=%b pc=%h i=%h p1=%h want pc=%h",
                                  k, bus_a.out_valid, bus_a.pc, bus_a.instr, bus_a.pc_plus1, 16'h0040 + 16'(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        start_a(1'b1);
        next_cycle();
        next_cycle();
        bus_a.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        bus_a.out_ready = 1'b1;
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 16'h0080;
        #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.pc, bus_a.imem_en} !== {1'b1, 16'h0000, 1'b0}) begin
            n_err++; $display("FAIL b2b_c4_full: got v=%b pc=%h en=%b want 1/0000/0",
                              bus_a.out_valid, bus_a.pc, bus_a.imem_en);
        end
        next_cycle();
        bus_a.redirect_pc = 16'h0090;
        #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.imem_en} !== 2'b00) begin
            n_err++; $display("FAIL b2b_c5_flushed: got v=%b en=%b want 0/0", bus_a.out_valid, bus_a.imem_en);
        end
        next_cycle();
        bus_a.redirect_valid = 1'b0;
        #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.imem_en} !== 2'b00) begin
            n_err++; $display("FAIL b2b_c6_bubble: got v=%b en=%b want 0/0", bus_a.out_valid, bus_a.imem_en);
        end
        next_cycle(); #1;
        n_vec++;
        if ({bus_a.imem_en, bus_a.imem_addr, bus_a.out_valid} !== {1'b1, 16'h0090, 1'b0}) begin
            n_err++; $display("FAIL b2b_c7_req: got en=%b a=%h v=%b want 1/0090/0",
                              bus_a.imem_en, bus_a.imem_addr, bus_a.out_valid);
        end
        next_cycle(); #1;
        n_vec++;
        if (bus_a.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_c8_empty: got v=%b want 0", bus_a.out_valid);
        end
        next_cycle(); #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.pc, bus_a.instr} !== {1'b1, 16'h0090, 16'hA090}) begin
            n_err++; $display("FAIL b2b_c9_target: got v=%b pc=%h i=%h want 1/0090/a090",
                              bus_a.out_valid, bus_a.pc, bus_a.instr);
        end
    endtask

    task automatic test_reset_pc();
        logic [15:0] exp_pc [3];
        logic [15:0] exp_p1 [3];
        exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000};
        exp_p1 = '{16'hFFFF, 16'h0000, 16'h0001};
        reset_b = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_b.redirect_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset_b = 1'b0;
        #1;
        n_vec++;
        if ({bus_b.imem_en, bus_b.imem_addr} !== {1'b1, 16'hFFFE}) begin
            n_err++; $display("FAIL wrap_c0_req: got %b/%h want 1/fffe", bus_b.imem_en, bus_b.imem_addr);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            n_vec++;
            if ({bus_b.out_valid, bus_b.pc, bus_b.pc_plus1, bus_b.instr} !==
                {1'b1, exp_pc[k], exp_p1[k], 16'hA000 + exp_pc[k]}) begin
                n_err++; $display("FAIL wrap_k%0d: got v=%b pc=%h p1=%h i=%h want pc=%h p1=%h",
                                  k, bus_b.out_valid, bus_b.pc, bus_b.pc_plus1, bus_b.instr, exp_pc[k], exp_p1[k]);
            end
        end
        reset_b = 1'b1;
    endtask

    task automatic test_reset_mid();
        start_a(1'b1);
        next_cycle();
        next_cycle();
        bus_a.out_ready = 1'b0;
        reset_a = 1'b1;
        #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.imem_en} !== 2'b10) begin
            n_err++; $display("FAIL rmid_pre: got v=%b en=%b want 1/0", bus_a.out_valid, bus_a.imem_en);
        end
        next_cycle();
        reset_a = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        n_vec++;
        if ({bus_a.out_valid, bus_a.imem_en, bus_a.imem_addr} !== {1'b0, 1'b1, 16'h0000}) begin
            n_err++; $display("FAIL rmid_cleared: got v=%b en=%b a=%h want 0/1/0000",
                              bus_a.out_valid, bus_a.imem_en, bus_a.imem_addr);
        end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            next_cycle(); #1;
            n_vec++;
            if ({bus_a.out_valid, bus_a.pc, bus_a.instr} !== {1'b1, 16'(k), 16'hA000 + 16'(k)}) begin
                n_err++; $display("FAIL rmid_k%0d: got v=%b pc=%h i=%h want pc=%h",
                                  k, bus_a.out_valid, bus_a.pc, bus_a.instr, 16'(k));
            end
        end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.out_ready = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = 16'h0000;
        bus_b.out_ready = 1'b1;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = 16'h0000;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_reset_pc();
        test_reset_mid();

        n_vec++;
        if (n_viol !== 0) begin
            n_err++; $display("FAIL queue_overflow: got %0d events want 0", n_viol);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
